// File: rtl/tm_pkg.sv
// Shared types and default sizing for the Tsetlin Machine inference datapath.
package tm_pkg;

    localparam int unsigned TM_STAGE_NUM = 13;
    localparam int unsigned TM_DATA_W    = 64;

    typedef enum logic {
        RECV = 1'b0,
        WAIT = 1'b1
    } seq_state_t;

endpackage : tm_pkg

// File: rtl/stage_onehot_dec.sv
// Combinational stage-index to one-hot decoder; the parent registers the result.
module stage_onehot_dec #(
    parameter int unsigned STAGE_NUM = 13,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [IDX_W-1:0]     idx_i,
    output logic [STAGE_NUM-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < STAGE_NUM; i++) begin
            if (idx_i == IDX_W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule : stage_onehot_dec

// File: rtl/tm_stream_sequencer.sv
// AXI-Stream slave that slices each datapoint into per-stage beats for the HCB
// stages and holds off the next datapoint until the inference top reports finish.
module tm_stream_sequencer
    import tm_pkg::*;
#(
    parameter int unsigned STAGE_NUM            = TM_STAGE_NUM,
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = TM_DATA_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] x,
    output logic [STAGE_NUM-1:0]            valid,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] packet_counter,
    output logic                            last,
    input  logic                            finish,
    output logic                            busy,
    output logic                            proto_err
);

    localparam int unsigned    IDX_W    = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
    localparam int unsigned    DW       = C_S_AXIS_TDATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE_NUM - 1);

    seq_state_t           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 tready_q;
    logic [DW-1:0]        x_q;
    logic [DW-1:0]        pc_q;
    logic [STAGE_NUM-1:0] valid_q;
    logic                 last_q;
    logic [STAGE_NUM-1:0] onehot_c;
    logic                 accept_c;
    logic                 final_c;
    logic                 early_last_c;

    assign accept_c     = s_axis_tvalid && tready_q;
    assign final_c      = (idx_q == LAST_IDX);
    assign early_last_c = accept_c && s_axis_tlast && !final_c;

    stage_onehot_dec #(
        .STAGE_NUM (STAGE_NUM),
        .IDX_W     (IDX_W)
    ) u_dec (
        .idx_i    (idx_q),
        .onehot_o (onehot_c)
    );

    // Next-state: beat indexing, datapoint handshake with finish, error capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            RECV: begin
                if (accept_c) begin
                    if (final_c) begin
                        idx_d   = '0;
                        state_d = WAIT;
                        busy_d  = 1'b1;
                    end else if (s_axis_tlast) begin
                        // Truncated datapoint: drop it and restart at stage 0
                        idx_d  = '0;
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        busy_d = 1'b1;
                    end
                end
                if (finish) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (finish) begin
                    state_d = RECV;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RECV;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            tready_q <= 1'b0;
            x_q      <= '0;
            pc_q     <= '0;
            valid_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            tready_q <= (state_d == RECV);
            valid_q  <= accept_c ? onehot_c : '0;
            last_q   <= accept_c && final_c && s_axis_tlast;
            // x and packet_counter hold across idle cycles
            if (accept_c) begin
                x_q  <= s_axis_tdata;
                pc_q <= DW'(idx_q);
            end
        end
    end

    assign s_axis_tready  = tready_q;
    assign x              = x_q;
    assign valid          = valid_q;
    assign packet_counter = pc_q;
    assign last           = last_q;
    assign busy           = busy_q;
    assign proto_err      = err_q;

    logic unused_early;
    assign unused_early = early_last_c;

endmodule : tm_stream_sequencer
